mem_arbiter: RTL and testbench

//  Shares one single-port synchronous memory (1-cycle read latency, CEN/WEN, word-addressed by A[11:2])

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port synchronous memory between instruction fetch and data load/store.
// Optional alignment check enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned CNT_W      = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  input  logic [31:0] mem_q,
  output logic        stall,
  output logic        align_err
);

  typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_DM} resp_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  resp_t            resp_sel, resp_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             if_ok, dm_ok;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic if_mis, dm_mis, align_q;

  assign if_mis = (if_addr[1:0] != 2'b00);
  assign dm_mis = (dm_addr[1:0] != 2'b00);
  // A misaligned requester drops out of arbitration, so it cannot block the other port.
  assign if_ok  = if_req & ~if_mis;
  assign dm_ok  = dm_req & ~dm_mis;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) align_q <= 1'b0;
    else       align_q <= align_q | (if_req & if_mis) | (dm_req & dm_mis);
  end

  assign align_err = align_q;
`else
  assign if_ok     = if_req;
  assign dm_ok     = dm_req;
  assign align_err = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (if_ok && dm_ok) begin
      if (starve_cnt == CNT_MAX) if_gnt = 1'b1;
      else                       dm_gnt = 1'b1;
    end else begin
      if_gnt = if_ok;
      dm_gnt = dm_ok;
    end
  end

  always_comb begin
    starve_nxt = '0;
    if (if_req && !if_gnt)
      starve_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
  end

  always_comb begin
    resp_nxt = RESP_NONE;
    if (if_gnt)                resp_nxt = RESP_IF;
    else if (dm_gnt && !dm_we) resp_nxt = RESP_DM;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      resp_sel   <= RESP_NONE;
      starve_cnt <= '0;
    end else begin
      resp_sel   <= resp_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  assign mem_cen   = if_gnt | dm_gnt;
  assign mem_wen   = dm_gnt & dm_we;
  assign mem_a     = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
  assign mem_d     = mem_wen ? dm_wdata : '0;
  assign stall     = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);

  assign if_rvalid = (resp_sel == RESP_IF);
  assign dm_rvalid = (resp_sel == RESP_DM);
  assign if_rdata  = if_rvalid ? mem_q : '0;
  assign dm_rdata  = dm_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written corner sequences and random traffic
// checked every cycle against a behavioural model with its own shadow memory.
module tb_mem_arbiter;

  localparam int unsigned SMAX = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] mem_q = '0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata, mem_a, mem_d;
  logic        mem_cen, mem_wen, stall, align_err;

  mem_arbiter #(.STARVE_MAX(SMAX), .CNT_W(2)) dut (
    .clk(clk), .nrst(nrst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
    .stall(stall), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) mem[mem_a[11:2]] <= mem_d;
      else         mem_q <= mem[mem_a[11:2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: how many cycles in a row fetch has been refused, plus the outstanding response.
  int unsigned denied = 0;
  bit          pend_if = 0, pend_dm = 0, ae = 0;
  logic [31:0] pend_data = '0;
  int unsigned n_denied;
  bit          n_pend_if, n_pend_dm, n_ae, st_do;
  logic [31:0] n_data, st_val;
  logic [9:0]  st_idx;

  logic        a_if_gnt, a_dm_gnt, a_stall, a_wen, a_if_rvalid, a_dm_rvalid, a_align;
  logic [31:0] a_mem_a, a_if_rdata, a_dm_rdata;

  task automatic model_check();
    bit          if_ok, dm_ok, e_if, e_dm, e_stall;
    logic [31:0] e_a, e_d;
    if (!nrst) begin
      denied = 0; pend_if = 0; pend_dm = 0; ae = 0;
    end
    if_ok = if_req;
    dm_ok = dm_req;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    if (if_addr[1:0] != 2'b00) if_ok = 0;
    if (dm_addr[1:0] != 2'b00) dm_ok = 0;
`endif
    e_if = 0;
    e_dm = 0;
    if (if_ok && dm_ok) begin
      if (denied >= SMAX) e_if = 1;
      else                e_dm = 1;
    end else begin
      e_if = if_ok;
      e_dm = dm_ok;
    end
    e_stall = (if_req && !e_if) || (dm_req && !e_dm);
    e_a     = e_if ? if_addr : (e_dm ? dm_addr : 32'h0);
    e_d     = (e_dm && dm_we) ? dm_wdata : 32'h0;

    chk1("if_gnt", if_gnt, e_if);
    chk1("dm_gnt", dm_gnt, e_dm);
    chk1("stall", stall, e_stall);
    chk1("mem_cen", mem_cen, e_if | e_dm);
    chk1("mem_wen", mem_wen, e_dm && dm_we);
    chk("mem_a", mem_a, e_a);
    chk("mem_d", mem_d, e_d);
    chk1("if_rvalid", if_rvalid, pend_if);
    chk("if_rdata", if_rdata, pend_if ? pend_data : 32'h0);
    chk1("dm_rvalid", dm_rvalid, pend_dm);
    chk("dm_rdata", dm_rdata, pend_dm ? pend_data : 32'h0);
    chk1("align_err", align_err, ae);

    a_if_gnt = if_gnt; a_dm_gnt = dm_gnt; a_stall = stall; a_wen = mem_wen; a_mem_a = mem_a;
    a_if_rvalid = if_rvalid; a_dm_rvalid = dm_rvalid; a_if_rdata = if_rdata; a_dm_rdata = dm_rdata;
    a_align = align_err;

    n_denied  = (if_req && !e_if) ? ((denied < SMAX) ? denied + 1 : SMAX) : 0;
    n_pend_if = e_if;
    n_pend_dm = e_dm && !dm_we;
    n_data    = ref_mem[e_a[11:2]];
    st_do     = e_dm && dm_we;
    st_idx    = dm_addr[11:2];
    st_val    = dm_wdata;
    n_ae      = ae;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    if ((if_req && if_addr[1:0] != 2'b00) || (dm_req && dm_addr[1:0] != 2'b00)) n_ae = 1;
`endif
  endtask

  task automatic model_commit();
    if (!nrst) begin
      denied = 0; pend_if = 0; pend_dm = 0; ae = 0;
    end else begin
      denied = n_denied; pend_if = n_pend_if; pend_dm = n_pend_dm; pend_data = n_data; ae = n_ae;
      if (st_do) ref_mem[st_idx] = st_val;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                     input logic [31:0] da, input logic [31:0] dd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
  endtask

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] dd;
    bit          e_if;
    bit          e_dm;
    bit          e_stall;
    logic [31:0] e_a;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 32'h100, 1, 0, 32'h200, 32'h0,        0, 1, 1, 32'h200};
    tbl[1] = '{1, 32'h100, 1, 0, 32'h200, 32'h0,        0, 1, 1, 32'h200};
    tbl[2] = '{1, 32'h100, 1, 0, 32'h200, 32'h0,        0, 1, 1, 32'h200};
    tbl[3] = '{1, 32'h100, 1, 0, 32'h200, 32'h0,        1, 0, 1, 32'h100};
    tbl[4] = '{1, 32'h100, 1, 0, 32'h200, 32'h0,        0, 1, 1, 32'h200};
    tbl[5] = '{1, 32'h100, 1, 0, 32'h200, 32'h0,        0, 1, 1, 32'h200};
    tbl[6] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0};
    tbl[7] = '{0, 32'h0,   1, 1, 32'h40,  32'hA5A5A5A5, 0, 1, 0, 32'h40};
    tbl[8] = '{1, 32'h44,  0, 0, 32'h0,   32'h0,        1, 0, 0, 32'h44};
    tbl[9] = '{0, 32'h0,   1, 0, 32'h40,  32'h0,        0, 1, 0, 32'h40};

    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    // Reset state
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk1("rst_if_rvalid", a_if_rvalid, 1'b0);
    chk1("rst_dm_rvalid", a_dm_rvalid, 1'b0);
    chk1("rst_align_err", a_align, 1'b0);
    step();
    nrst = 1'b1;

    // Lone fetch read
    drv(1, 32'h10, 0, 0, 0, 0);
    step();
    chk1("t1_if_gnt", a_if_gnt, 1'b1);
    chk("t1_mem_a", a_mem_a, 32'h10);
    chk1("t1_stall", a_stall, 1'b0);
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk1("t1_if_rvalid", a_if_rvalid, 1'b1);
    chk("t1_if_rdata", a_if_rdata, 32'hDEADBEEF);
    chk1("t1_stall_resp", a_stall, 1'b0);

    // Directed table, including the starvation pattern DM,DM,DM,IF,DM,DM
    for (int i = 0; i < 10; i++) begin
      drv(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      step();
      chk1($sformatf("tbl%0d_if_gnt", i), a_if_gnt, tbl[i].e_if);
      chk1($sformatf("tbl%0d_dm_gnt", i), a_dm_gnt, tbl[i].e_dm);
      chk1($sformatf("tbl%0d_stall", i), a_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_mem_a", i), a_mem_a, tbl[i].e_a);
    end
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk("tbl_load_back", a_dm_rdata, 32'hA5A5A5A5);

    // Store then load to the same address
    drv(0, 0, 1, 1, 32'h20, 32'h12345678);
    step();
    chk1("t3_wen", a_wen, 1'b1);
    chk1("t3_no_rvalid0", a_dm_rvalid, 1'b0);
    drv(0, 0, 1, 0, 32'h20, 0);
    step();
    chk1("t3_no_rvalid1", a_dm_rvalid, 1'b0);
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk1("t3_rvalid", a_dm_rvalid, 1'b1);
    chk("t3_rdata", a_dm_rdata, 32'h12345678);

    // Stall while data wins, released once data drops its request
    drv(1, 32'h80, 1, 0, 32'h90, 0);
    step();
    chk1("t5_stall", a_stall, 1'b1);
    chk1("t5_if_gnt", a_if_gnt, 1'b0);
    chk("t5_mem_a", a_mem_a, 32'h90);
    drv(1, 32'h80, 0, 0, 0, 0);
    step();
    chk1("t5_stall_off", a_stall, 1'b0);
    chk1("t5_if_gnt_after", a_if_gnt, 1'b1);

    // Reset between a fetch grant and its response
    drv(1, 32'h84, 0, 0, 0, 0);
    @(negedge clk);
    model_check();
    chk1("t4_if_gnt", a_if_gnt, 1'b1);
    #2 nrst = 1'b0;
    @(posedge clk);
    model_commit();
    #1 nrst = 1'b1;
    drv(1, 32'h100, 1, 0, 32'h200, 0);
    step();
    chk1("t4_no_rvalid", a_if_rvalid, 1'b0);
    chk1("t4_dm_first", a_dm_gnt, 1'b1);
    for (int k = 0; k < 3; k++) step();
    chk1("t4_starve_restart", a_if_gnt, 1'b1);

    // Misaligned data request alongside a fetch
    drv(0, 0, 0, 0, 0, 0);
    step();
    drv(1, 32'h30, 1, 0, 32'h22, 0);
    step();
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk1("t6_if_gnt", a_if_gnt, 1'b1);
    chk1("t6_dm_gnt", a_dm_gnt, 1'b0);
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk1("t6_align_set", a_align, 1'b1);
    step();
    chk1("t6_align_sticky", a_align, 1'b1);
`else
    chk1("t6_dm_gnt", a_dm_gnt, 1'b1);
    chk("t6_mem_a", a_mem_a, 32'h22);
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk1("t6_align_zero", a_align, 1'b0);
`endif

    // Random traffic against the model
    nrst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step();
    nrst = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ia, da;
      ia = $urandom & 32'h0000_0FFC;
      da = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      drv($urandom_range(0, 3) != 0, ia, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
          da, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
